// File: rtl/mux_sel_pipe_pkg.sv
// Shared types for the select-and-buffer stage.
// Source tags, occupancy states and the buffered entry layout.
package mux_sel_pipe_pkg;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_D1   = 2'b01;
  localparam logic [1:0] SRC_D2   = 2'b10;

  localparam int ENTRY_DATA_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] data;
    logic [1:0]              src;
  } entry_t;

endpackage

// File: rtl/mux_sel_pipe_skid.sv
// Two-entry skid buffer: head register drives the output,
// skid register catches one beat while the head is stalled.
module mux_sel_pipe_skid
  import mux_sel_pipe_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_t         state, state_nxt;
  logic [W-1:0] head, head_nxt;
  logic [W-1:0] skid, skid_nxt;
  logic         push, pop;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = head;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      skid  <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    unique case (state)
      EMPTY: begin
        if (push) begin
          head_nxt  = in_data;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_nxt = in_data;
        end else if (push) begin
          skid_nxt  = in_data;
          state_nxt = TWO;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_nxt  = skid;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// Select-resolving consumer stage feeding a 2-entry skid buffer.
// Define MUX_SEL_PIPE_DROP_CNT_EN to build the saturating drop counter.
module mux_sel_pipe
  import mux_sel_pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel1,
  input  logic              in_sel2,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic [CNT_W-1:0]  drop_count
);

  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_src;
  logic              hit;

  always_comb begin
    sel_data = '0;
    sel_src  = SRC_NONE;
    priority case (1'b1)
      in_sel1: begin
        sel_data = in_data1;
        sel_src  = SRC_D1;
      end
      in_sel2: begin
        sel_data = in_data2;
        sel_src  = SRC_D2;
      end
      default: ;
    endcase
  end

  assign hit = (sel_src != SRC_NONE);

  // no-select beats are consumed here and never reach the buffer
  mux_sel_pipe_skid #(
    .W(DATA_W + 2)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid && hit),
    .in_ready (in_ready),
    .in_data  ({sel_data, sel_src}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data ({out_data, out_src})
  );

`ifdef MUX_SEL_PIPE_DROP_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic             drop;

  assign drop = in_valid && in_ready && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (drop && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign drop_count = cnt;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: queue-based reference model plus directed
// literal checks, then a randomized run checked every cycle.
module tb_mux_sel_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel1;
  logic        in_sel2;
  logic [15:0] in_data1;
  logic [15:0] in_data2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  src;
  } ent_t;

  ent_t q[$];
  int   mcnt = 0;
  bit   m_acc;
  bit   m_pop;

  always #5 clk = ~clk;

  mux_sel_pipe #(
    .DATA_W(16),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel1   (in_sel1),
    .in_sel2   (in_sel2),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .drop_count(drop_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  // Reference: a FIFO of at most two entries, plus a saturating count.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_pop = (q.size() > 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_acc) begin
        if (in_sel1) q.push_back('{in_data1, 2'b01});
        else if (in_sel2) q.push_back('{in_data2, 2'b10});
`ifdef MUX_SEL_PIPE_DROP_CNT_EN
        else if (mcnt < 255) mcnt++;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("drop_count", 32'(drop_count), 32'(mcnt));
      if (q.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(q[0].data));
        chk("out_src", 32'(out_src), 32'(q[0].src));
      end
    end
  end

  task automatic step(input bit v, input bit s1, input bit s2,
                      input logic [15:0] d1, input logic [15:0] d2,
                      input bit rdy);
    in_valid  = v;
    in_sel1   = s1;
    in_sel2   = s2;
    in_data1  = d1;
    in_data2  = d2;
    out_ready = rdy;
    @(negedge clk);
  endtask

  localparam int EXP_DROP3 =
`ifdef MUX_SEL_PIPE_DROP_CNT_EN
    3;
`else
    0;
`endif

  localparam int EXP_SAT =
`ifdef MUX_SEL_PIPE_DROP_CNT_EN
    255;
`else
    0;
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel1   = 1'b0;
    in_sel2   = 1'b0;
    in_data1  = '0;
    in_data2  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    armed = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst out_src", 32'(out_src), 0);
    chk("rst drop", 32'(drop_count), 0);

    step(1, 1, 0, 16'd4096, 16'd1234, 1);
    chk("d1 valid", 32'(out_valid), 1);
    chk("d1 data", 32'(out_data), 4096);
    chk("d1 src", 32'(out_src), 1);

    step(1, 0, 1, 16'd4096, 16'd1234, 1);
    chk("d2 data", 32'(out_data), 1234);
    chk("d2 src", 32'(out_src), 2);

    step(1, 1, 1, 16'd2048, 16'd1234, 1);
    chk("prio data", 32'(out_data), 2048);
    chk("prio src", 32'(out_src), 1);

    repeat (3) step(1, 0, 0, 16'd9, 16'd9, 1);
    chk("drop valid", 32'(out_valid), 0);
    chk("drop3 count", 32'(drop_count), EXP_DROP3);

    step(1, 1, 0, 16'd1024, 16'd0, 0);
    step(1, 1, 0, 16'd5678, 16'd0, 0);
    chk("full in_ready", 32'(in_ready), 0);
    chk("full head", 32'(out_data), 1024);
    step(0, 0, 0, 16'd0, 16'd0, 1);
    chk("drain 2nd", 32'(out_data), 5678);
    chk("drain in_ready", 32'(in_ready), 1);
    step(0, 0, 0, 16'd0, 16'd0, 1);
    chk("drain empty", 32'(out_valid), 0);

    step(1, 1, 0, 16'd1111, 16'd0, 0);
    step(1, 1, 0, 16'd5678, 16'd0, 1);
    chk("pp valid", 32'(out_valid), 1);
    chk("pp data", 32'(out_data), 5678);
    chk("pp in_ready", 32'(in_ready), 1);

    step(1, 1, 0, 16'd7, 16'd0, 0);
    chk("two in_ready", 32'(in_ready), 0);
    rst = 1'b1;
    step(0, 0, 0, 16'd0, 16'd0, 1);
    rst = 1'b0;
    chk("mid rst valid", 32'(out_valid), 0);
    chk("mid rst ready", 32'(in_ready), 1);
    chk("mid rst drop", 32'(drop_count), 0);
    step(0, 0, 0, 16'd0, 16'd0, 1);
    chk("flushed", 32'(out_valid), 0);

    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    repeat (300) step(1, 0, 0, 16'd0, 16'd0, 1);
    chk("drop sat", 32'(drop_count), EXP_SAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
